i2c_slave_fsm: RTL and testbench
================================

// Module: i2c_slave_fsm
// PURPOSE
//  I2C target (slave) endpoint: the downstream consumer of the master's scl/sda pair.
//  - Oversamples scl/sda on the system clock and detects START/STOP.
//  - Decodes the 7-bit address + R/W bit and ACKs only its own address.
//  - Writes: receives up to NUM_BYTES bytes; reads: returns bytes from tx_data_*.
//  - Bench counterpart and on-chip loopback target for the master FSM.
// PARAMETERS
//  SLAVE_ADDR  7'h2A  own 7-bit bus address
//  ADDR_LEN    7      address width
//  DATA_LEN    8      byte width
//  NUM_BYTES   2      data bytes accepted/returned per transfer (matches data_1/data_2)
//  SYNC_STAGES 2      synchroniser depth on scl_in/sda_in, >=2
// PORTS
//  clk            in   1         system clock; all logic on rising edge
//  rst            in   1         synchronous, active-high reset
//  scl_in         in   1         bus clock as seen on the wire
//  sda_in         in   1         bus data as seen on the wire (resolved open-drain value)
//  sda_drive_low  out  1         1 = pull sda low; 0 = release (external pull-up)
//  tx_data_1      in   DATA_LEN  first byte returned on a read
//  tx_data_2      in   DATA_LEN  second byte returned on a read
//  rx_data        out  DATA_LEN  last byte received on a write
//  rx_valid       out  1         1-cycle pulse: rx_data/rx_index updated
//  rx_index       out  clog2(NUM_BYTES) (min 1)  byte position in current transfer, 0-based
//  addr_match     out  1         high from own-address ACK until STOP/repeated START
//  busy           out  1         high between any START and the next STOP
// BEHAVIOUR
//  Reset: sda_drive_low=0, rx_data=0, rx_valid=0, rx_index=0, addr_match=0, busy=0, state=IDLE.
//  Sampling: scl_s/sda_s = SYNC_STAGES-flop outputs; edges from scl_s vs. its 1-cycle delay.
//   Requirement: each scl high/low phase >= 4 clk cycles.
//  START = sda_s falls while scl_s high; STOP = sda_s rises while scl_s high.
//   Both take priority over any state; START sets busy, STOP clears busy and addr_match.
//  States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
//  Sampling/drive rule: bits are sampled on the scl_s rising edge (MSB first).
//   sda_drive_low changes only in the cycle after a detected scl_s falling edge.
//  IDLE -> ADDR on START; bit counter cleared.
//  ADDR: shift ADDR_LEN+1 bits. After the 8th rising edge:
//   - address == SLAVE_ADDR -> ADDR_ACK: drive low from next scl fall for one bit time.
//   - otherwise -> IGNORE: never drive sda; leave only on START or STOP.
//  ADDR_ACK end (next scl fall): release; set addr_match; byte index = 0.
//   R/W=0 -> WR_DATA; R/W=1 -> RD_DATA, and the MSB of byte 0 is driven on that same fall.
//  WR_DATA: after 8 bits, if index<NUM_BYTES: rx_data<=byte, rx_index<=index, rx_valid
//   pulses 1 cycle (cycle after the 8th rise), ACK; otherwise NACK (release) and no rx_valid.
//  WR_ACK: release on next fall; index saturates at NUM_BYTES; -> WR_DATA.
//  RD_DATA: drive_low = ~bit. Bytes, by index: 0 -> tx_data_1, 1 -> tx_data_2, >=NUM_BYTES -> 8'hFF.
//   tx byte latched at the fall that starts the byte. Release after 8th bit -> RD_ACK.
//  RD_ACK: sample sda_s at rise.
//   - 0 (ACK): index+1 -> RD_DATA.
//   - 1 (NACK) -> IGNORE, released.
//  Boundaries:
//   - STOP mid-byte -> IDLE; partial byte discarded, no rx_valid.
//   - Repeated START anywhere -> ADDR; sda released in the same cycle as detection.
//   - START and STOP are exclusive by definition (same sda edge).
//   - General-call address 0 is not ACKed.
//   - rst mid-transfer -> release sda next cycle; resume only on a fresh START.
//  Invariant: sda_drive_low never asserts in IDLE or IGNORE.
// STRUCTURE
//  Package i2c_pkg:
//   - i2c_slave_state_t enum.
//   - I2C_ADDR_LEN=7 and I2C_DATA_LEN=8 constants.
//   - RW_WRITE=0 / RW_READ=1.
//  Sub-module i2c_bus_sampler: synchronisers and delay flops.
//   Outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det.
//  Top holds the FSM, the bit counter (0..8), the byte index and the shift registers.
// TESTING
//  1. Write to 0x2A, bytes 0xA5,0x3C ->
//     - ACK on addr and both bytes.
//     - rx_valid twice: (0xA5,idx0), (0x3C,idx1).
//     - busy falls on STOP.
//  2. Write to 0x15 -> no sda_drive_low at any cycle; addr_match=0; no rx_valid; busy 1 until STOP.
//  3. Read from 0x2A, tx_data_1=0x81, tx_data_2=0x7E, master ACKs byte0 and NACKs byte1 ->
//     - bits 10000001, then 01111110 on sda.
//     - sda released after the NACK.
//  4. Write 3 bytes 0x11,0x22,0x33 -> first two ACKed with rx_valid; third NACKed, no rx_valid.
//  5. STOP after 4 bits of a data byte, then repeated START + read ->
//     - no rx_valid for the partial byte.
//     - new address decoded; the read returns 0x81.
//  6. Assert rst while slave drives ACK -> sda_drive_low=0 next cycle; all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target endpoint.
package i2c_pkg;
   localparam int I2C_ADDR_LEN = 7;
   localparam int I2C_DATA_LEN = 8;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ = 1'b1;
   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } i2c_slave_state_t;
endpackage

// File: rtl/i2c_bus_sampler.sv
// i2c_bus_sampler: synchronises scl/sda into the clk domain and flags scl edges and START/STOP.
module i2c_bus_sampler #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_d = scl_s;
      sda_dly_d = sda_s;
   end
   // Reset to the idle bus level so leaving reset never fakes an edge on a quiet bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_dly_q <= 1'b1;
         sda_dly_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_dly_q <= scl_dly_d;
         sda_dly_q <= sda_dly_d;
      end
   end
   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_dly_q;
   assign scl_fall = ~scl_s & scl_dly_q;
   assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
   assign stop_det = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
endmodule

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target that ACKs its own address, accepts NUM_BYTES written bytes
// and returns tx_data_1/tx_data_2 on reads.
module i2c_slave_fsm
   import i2c_pkg::*;
#(
   parameter int ADDR_LEN = I2C_ADDR_LEN,
   parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h2A,
   parameter int DATA_LEN = I2C_DATA_LEN,
   parameter int NUM_BYTES = 2,
   parameter int SYNC_STAGES = 2,
   localparam int IW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scl_in,
   input  logic                sda_in,
   output logic                sda_drive_low,
   input  logic [DATA_LEN-1:0] tx_data_1,
   input  logic [DATA_LEN-1:0] tx_data_2,
   output logic [DATA_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic [IW-1:0]       rx_index,
   output logic                addr_match,
   output logic                busy
);
   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam int BW = $clog2(DATA_LEN + 1);
   i2c_slave_state_t state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [CW-1:0] idx_q, idx_d, idx_inc;
   logic [DATA_LEN-1:0] shift_q, shift_d, tx_q, tx_d, rx_data_q, rx_data_d, byte_in, tx_sel;
   logic [IW-1:0] rx_index_q, rx_index_d;
   logic rw_q, rw_d, drive_q, drive_d, rx_valid_q, rx_valid_d;
   logic addr_match_q, addr_match_d, busy_q, busy_d;
   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, rise, in_range;

   i2c_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
      .scl_s(scl_s), .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_det(start_det), .stop_det(stop_det)
   );

   assign rise = scl_rise & scl_s;
   assign byte_in = {shift_q[DATA_LEN-2:0], sda_s};
   assign in_range = idx_q < CW'(NUM_BYTES);
   assign idx_inc = in_range ? idx_q + 1'b1 : idx_q;
   assign tx_sel = (idx_q == '0) ? tx_data_1 : (idx_q == CW'(1) && NUM_BYTES > 1) ? tx_data_2 : '1;

   always_comb begin
      state_d = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d = idx_q;
      shift_d = shift_q;
      tx_d = tx_q;
      rw_d = rw_q;
      drive_d = drive_q;
      rx_data_d = rx_data_q;
      rx_index_d = rx_index_q;
      rx_valid_d = 1'b0;
      addr_match_d = addr_match_q;
      busy_d = busy_q;
      if (start_det) begin
         state_d = ADDR;
         bit_cnt_d = '0;
         drive_d = 1'b0;
         addr_match_d = 1'b0;
         busy_d = 1'b1;
      end else if (stop_det) begin
         state_d = IDLE;
         drive_d = 1'b0;
         addr_match_d = 1'b0;
         busy_d = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (rise) begin
               shift_d = byte_in;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BW'(ADDR_LEN)) begin
                  rw_d = sda_s;
                  state_d = (shift_q[ADDR_LEN-1:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
               end
            end
            // Ack states: first fall (count still full) opens the ack bit, the next one closes it.
            ADDR_ACK: if (scl_fall) begin
               bit_cnt_d = '0;
               if (bit_cnt_q == BW'(ADDR_LEN + 1)) drive_d = 1'b1;
               else begin
                  addr_match_d = 1'b1;
                  idx_d = '0;
                  state_d = (rw_q == RW_READ) ? RD_DATA : WR_DATA;
                  tx_d = tx_data_1;
                  drive_d = (rw_q == RW_READ) ? ~tx_data_1[DATA_LEN-1] : 1'b0;
               end
            end
            WR_DATA: if (rise) begin
               shift_d = byte_in;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BW'(DATA_LEN - 1)) begin
                  state_d = WR_ACK;
                  rx_valid_d = in_range;
                  rx_data_d = in_range ? byte_in : rx_data_q;
                  rx_index_d = in_range ? IW'(idx_q) : rx_index_q;
               end
            end
            WR_ACK: if (scl_fall) begin
               bit_cnt_d = '0;
               if (bit_cnt_q == BW'(DATA_LEN)) drive_d = in_range;
               else begin
                  drive_d = 1'b0;
                  idx_d = idx_inc;
                  state_d = WR_DATA;
               end
            end
            RD_DATA: if (rise) bit_cnt_d = bit_cnt_q + 1'b1;
            else if (scl_fall) begin
               if (bit_cnt_q == BW'(DATA_LEN)) begin
                  drive_d = 1'b0;
                  state_d = RD_ACK;
               end else begin
                  tx_d = tx_q << 1;
                  drive_d = ~tx_q[DATA_LEN-2];
               end
            end
            RD_ACK: if (rise) begin
               state_d = sda_s ? IGNORE : RD_ACK;
               idx_d = sda_s ? idx_q : idx_inc;
            end else if (scl_fall) begin
               state_d = RD_DATA;
               bit_cnt_d = '0;
               tx_d = tx_sel;
               drive_d = ~tx_sel[DATA_LEN-1];
            end
            default: drive_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bit_cnt_q <= '0;
         idx_q <= '0;
         shift_q <= '0;
         tx_q <= '0;
         rw_q <= RW_WRITE;
         drive_q <= 1'b0;
         rx_data_q <= '0;
         rx_index_q <= '0;
         rx_valid_q <= 1'b0;
         addr_match_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q <= idx_d;
         shift_q <= shift_d;
         tx_q <= tx_d;
         rw_q <= rw_d;
         drive_q <= drive_d;
         rx_data_q <= rx_data_d;
         rx_index_q <= rx_index_d;
         rx_valid_q <= rx_valid_d;
         addr_match_q <= addr_match_d;
         busy_q <= busy_d;
      end
   end

   assign sda_drive_low = drive_q;
   assign rx_data = rx_data_q;
   assign rx_index = rx_index_q;
   assign rx_valid = rx_valid_q;
   assign addr_match = addr_match_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: bus-level master driving i2c_slave_fsm, checked against a transaction-level model.
module tb_i2c_slave_fsm;
   localparam logic [6:0] SLAVE = 7'h2A;
   localparam int NB = 2;
   localparam int Q = 5;
   logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1, sda_bus;
   logic [7:0] tx1 = 8'h81, tx2 = 8'h7E, rx_data;
   logic sda_drive_low, rx_valid, addr_match, busy;
   logic [0:0] rx_index;
   logic [8:0] rx_q[$];
   int n_vec = 0, n_err = 0, drv_cnt = 0;

   assign sda_bus = sda_m & ~sda_drive_low;

   i2c_slave_fsm dut (
      .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_drive_low(sda_drive_low),
      .tx_data_1(tx1), .tx_data_2(tx2), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_index(rx_index), .addr_match(addr_match), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sda_drive_low) drv_cnt++;
      if (rx_valid) rx_q.push_back({rx_index, rx_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_start();
      tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
   endtask

   task automatic bit_io(input logic b, output logic r);
      tick(Q); sda_m = b; tick(Q); scl = 1'b1; tick(Q); r = sda_bus; tick(Q); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(d[i], r);
      bit_io(1'b1, ack);
   endtask

   task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
      logic r;
      for (int i = 0; i < 8; i++) begin
         bit_io(1'b1, r);
         d = {d[6:0], r};
      end
      bit_io(ack_bit, r);
   endtask

   function automatic logic [7:0] exp_rd(input int i);
      return i == 0 ? tx1 : i == 1 ? tx2 : 8'hFF;
   endfunction

   task automatic wr_xfer(input logic [6:0] a, input int n, input logic [7:0] d[4]);
      bit m;
      int d0, ne;
      logic ack;
      m = (a == SLAVE);
      ne = m ? (n < NB ? n : NB) : 0;
      d0 = drv_cnt;
      rx_q.delete();
      bus_start();
      check("busy_start", busy, 1);
      send_byte({a, 1'b0}, ack);
      check("wr_addr_ack", ack, !m);
      for (int i = 0; i < n; i++) begin
         send_byte(d[i], ack);
         check("wr_data_ack", ack, !(m && i < NB));
      end
      tick(Q);
      check("wr_addr_match", addr_match, m);
      check("busy_mid", busy, 1);
      bus_stop();
      check("busy_stop", busy, 0);
      check("am_stop", addr_match, 0);
      check("rx_count", rx_q.size(), ne);
      for (int i = 0; i < ne && i < rx_q.size(); i++) check("rx_event", rx_q[i], {i[0], d[i]});
      if (!m) check("no_drive", drv_cnt - d0, 0);
   endtask

   task automatic rd_xfer(input logic [6:0] a, input int n);
      bit m;
      logic ack;
      logic [7:0] d;
      m = (a == SLAVE);
      rx_q.delete();
      bus_start();
      check("busy_start", busy, 1);
      send_byte({a, 1'b1}, ack);
      check("rd_addr_ack", ack, !m);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         check("rd_byte", d, m ? exp_rd(i) : 8'hFF);
      end
      tick(Q);
      check("rd_release", sda_drive_low, 0);
      bus_stop();
      check("busy_stop", busy, 0);
      check("rd_no_rx", rx_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_drv"}, sda_drive_low, 0);
      check({tag, "_rxd"}, rx_data, 0);
      check({tag, "_rxv"}, rx_valid, 0);
      check({tag, "_rxi"}, rx_index, 0);
      check({tag, "_am"}, addr_match, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      logic ack, r;
      logic [6:0] a;
      logic [7:0] rd[4];
      tick(3);
      rst = 1'b0;
      tick(1);
      check_reset("reset");
      wr_xfer(SLAVE, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00});
      wr_xfer(7'h15, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00});
      rd_xfer(SLAVE, 2);
      wr_xfer(SLAVE, 3, '{8'h11, 8'h22, 8'h33, 8'h00});
      wr_xfer(7'h00, 1, '{8'h5A, 8'h00, 8'h00, 8'h00});
      // STOP after four data bits, then a write header followed by a repeated START read.
      bus_start();
      send_byte({SLAVE, 1'b0}, ack);
      check("part_addr_ack", ack, 0);
      rx_q.delete();
      for (int i = 0; i < 4; i++) bit_io(i[0], r);
      bus_stop();
      check("part_no_rx", rx_q.size(), 0);
      check("part_busy", busy, 0);
      bus_start();
      send_byte({SLAVE, 1'b0}, ack);
      check("rs_addr_ack", ack, 0);
      rd_xfer(SLAVE, 1);
      // Reset while the address ACK is being driven.
      bus_start();
      for (int i = 7; i >= 0; i--) bit_io(i == 0 ? 1'b0 : SLAVE[i-1], r);
      tick(Q);
      check("ack_driven", sda_drive_low, 1);
      rst = 1'b1;
      tick(1);
      check_reset("midrst");
      scl = 1'b1;
      sda_m = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(Q);
      check_reset("postrst");
      wr_xfer(SLAVE, 1, '{8'hC3, 8'h00, 8'h00, 8'h00});
      for (int k = 0; k < 16; k++) begin
         a = $urandom_range(0, 1) ? SLAVE : 7'($urandom);
         tx1 = 8'($urandom);
         tx2 = 8'($urandom);
         for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
         if ($urandom_range(0, 1) == 1) wr_xfer(a, $urandom_range(0, 3), rd);
         else rd_xfer(a, $urandom_range(1, 3));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
